tristate_rx: RTL and testbench
==============================

Name: tristate_rx

Overview:
Receive side of the half-duplex single-wire link whose drive side is a tristate buffer controlled by oe.
- Samples the shared pin whenever the local driver is released, and decodes 8N1 async frames (LSB first).
- Presents each byte on a valid/ready handshake to the host-interface logic.
- Blanks itself while the local driver is enabled and for a guard interval afterwards, so it never decodes its own transmissions or the turnaround glitch.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit cell; must be >= 8.
GUARD, 4, cycles the receiver stays blanked after oe falls; 0 is legal.

Ports:
clk  in  1  system clock; every register updates on its rising edge.
rst_n  in  1  synchronous, active-low reset.
pin_in  in  1  raw (asynchronous) level of the shared pin.
oe  in  1  the same enable that drives the pin's tristate buffer; 1 = local side driving.
rx_data  out  8  received byte; stable while rx_valid = 1.
rx_valid  out  1  byte available; held until it is accepted.
rx_ready  in  1  consumer accepts the byte when rx_valid and rx_ready are both 1.
overrun  out  1  1-cycle pulse: a byte completed while the previous byte was unaccepted.
frame_err  out  1  1-cycle pulse: the stop bit was sampled as 0.
busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - rx_data = 0, rx_valid = 0, overrun = 0, frame_err = 0, busy = 0.
  - State = IDLE.
  - Synchronizer and filter preset to 1 (line idle high).
  - Guard counter = 0.
  - Reset takes priority over every other event, including mid-frame; the partial byte is discarded.
- Line conditioning:
  - 2-FF synchronizer on pin_in, followed by a 3-tap majority filter, giving line_f.
  - Pin-to-line_f latency is 3–4 cycles.
- Blanking:
  - blank = oe OR (guard counter != 0).
  - The guard counter loads GUARD on every cycle oe = 1 and decrements to 0 after oe falls.
  - While blank = 1, the state is forced to IDLE and the edge detector is re-armed with the current line_f value.
- States:
  - IDLE:
    - A falling edge on line_f with blank = 0 → START; bit counter cleared to CLKS_PER_BIT/2 - 1.
  - START (mid-bit check at CLKS_PER_BIT/2):
    - line_f = 0 → DATA; bit index = 0; counter reloaded to CLKS_PER_BIT - 1.
    - line_f = 1 → IDLE (false start). No error is flagged.
  - DATA:
    - Sample line_f when the counter reaches 0 and shift it in LSB first.
    - After bit 7 → STOP.
  - STOP (sampled one bit period after bit 7):
    - 1 → deliver the byte (see the handshake rules); return to IDLE.
    - 0 → pulse frame_err, discard the byte, return to IDLE. The next start is detected only after line_f returns to 1 and falls again.
- Handshake:
  - Delivery registers rx_data and sets rx_valid on the cycle after the stop-bit sample.
  - Accept (rx_valid & rx_ready) clears rx_valid on the next cycle.
  - Delivery while rx_valid = 1 and no accept in the same cycle: pulse overrun; the new byte is dropped and the old byte stays.
  - Delivery in the same cycle as an accept: the new byte is loaded, rx_valid stays 1, no overrun.
- Abort rule: if oe rises mid-frame, the receiver returns to IDLE immediately with no error and no delivery.
- Counter width is $clog2(CLKS_PER_BIT). The bit counter counts down and reloads, so it has no wrap-around ambiguity.

Decomposition:
- Package tristate_rx_pkg:
  - State enum (IDLE, START, DATA, STOP).
  - Constants DATA_BITS = 8 and STOP_LEVEL = 1.
- Sub-module line_filter (synchronizer + majority vote), reusable on other shared pins.
- The FSM, guard counter and handshake stay in tristate_rx.

Test Plan:
All scenarios use CLKS_PER_BIT = 16 and GUARD = 4.
- Frame 0xA5 with rx_ready = 1 → rx_data = 0xA5; rx_valid pulses for 1 cycle, asserting 9.5 bit-times plus 3–5 cycles after the start edge; no error pulses.
- Two back-to-back frames 0x3C then 0xC3 with rx_ready held at 0 → rx_data = 0x3C; overrun pulses once at the second stop bit. Then set rx_ready = 1 → rx_valid falls next cycle.
- Glitch low for 4 cycles while idle → START then back to IDLE; no rx_valid, no frame_err; busy returns to 0.
- Frame 0x55 with the stop bit forced to 0 → frame_err pulses for 1 cycle; rx_valid stays 0. A following valid frame 0x12 is received correctly.
- oe = 1 while the pin carries 0x7E, then oe falls and the pin drops low 2 cycles later → nothing decoded. A frame 0x81 started after the 4-cycle guard → 0x81 delivered.
- rst_n = 0 during bit 3 of frame 0xFF → all outputs 0 on the next cycle; the partial byte is never delivered, and the next frame 0x0F is received correctly.

Source files
------------

// File: rtl/tristate_rx_pkg.sv
// Shared types and constants for the single-wire half-duplex receiver.
package tristate_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/line_filter.sv
// Two-flop synchronizer plus 3-tap majority vote; idles high. Pin to line_f takes 3-4 cycles.
module line_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic line_f
);

  logic [1:0] sync;
  logic [1:0] taps;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      taps   <= 2'b11;
      line_f <= 1'b1;
    end else begin
      sync   <= {sync[0], pin_in};
      taps   <= {taps[0], sync[1]};
      line_f <= (sync[1] & taps[0]) | (sync[1] & taps[1]) | (taps[0] & taps[1]);
    end
  end

endmodule

// File: rtl/tristate_rx.sv
// 8N1 receiver for a shared single-wire pin, blanked while the local driver owns the line
// and for GUARD cycles after release; bytes leave on a valid/ready handshake.
module tristate_rx
  import tristate_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int GUARD        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pin_in,
  input  logic                 oe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GUARD_LOAD  = GW'(GUARD);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [GW-1:0]        guard;
  logic                 line_f;
  logic                 line_prev;
  logic                 blank;
  logic                 good_stop;
  logic                 bad_stop;
  logic                 accept;

  line_filter u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (pin_in),
    .line_f (line_f)
  );

  assign blank  = oe | (guard != '0);
  assign accept = rx_valid & rx_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (blank) begin
      // Own transmission or turnaround: drop any frame in progress silently.
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (line_prev && !line_f) begin
            state_n = START;
            cnt_n   = HALF_RELOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!line_f) begin
              state_n = DATA;
              bit_n   = '0;
              cnt_n   = BIT_RELOAD;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg_n = {line_f, shreg[DATA_BITS-1:1]};
            cnt_n   = BIT_RELOAD;
            if (bit_idx == LAST_BIT) state_n = STOP;
            else                     bit_n   = bit_idx + 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            state_n = IDLE;
            if (line_f == STOP_LEVEL) good_stop = 1'b1;
            else                      bad_stop  = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      line_prev <= 1'b1;
      guard     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shreg     <= shreg_n;
      line_prev <= line_f;
      overrun   <= 1'b0;
      frame_err <= bad_stop;

      if (oe)                guard <= GUARD_LOAD;
      else if (guard != '0)  guard <= guard - 1'b1;

      // A byte landing on an accept cycle replaces the outgoing one without a gap.
      if (good_stop) begin
        if (!rx_valid || accept) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tristate_rx.sv
// Directed bench for tristate_rx: 16 clocks per bit, 4-cycle guard.
module tb_tristate_rx;

  logic       clk;
  logic       rst_n;
  logic       pin_in;
  logic       oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  int acc_cnt = 0;
  int vhi_cnt = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int rise_cyc = 0;
  logic [7:0] last_acc = 8'h00;
  logic pv = 1'b0;

  int a0, v0, o0, f0, b0, lat;

  tristate_rx #(.CLKS_PER_BIT(16), .GUARD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_in    (pin_in),
    .oe        (oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) vhi_cnt++;
    if (rx_valid && !pv) rise_cyc = cyc;
    pv = rx_valid;
    if (rx_valid && rx_ready) begin
      acc_cnt++;
      last_acc = rx_data;
    end
    if (overrun) ovr_cnt++;
    if (frame_err) ferr_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    pin_in  = 1'b0;
    t_start = cyc;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      pin_in = b[i];
      idle(16);
    end
    pin_in = stop;
    idle(16);
  endtask

  initial begin
    rst_n    = 1'b0;
    pin_in   = 1'b1;
    oe       = 1'b0;
    rx_ready = 1'b1;
    idle(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Single frame, consumer always ready
    a0 = acc_cnt; v0 = vhi_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    idle(20);
    lat = rise_cyc - t_start - 1;
    check("a5_accepts", acc_cnt - a0, 1);
    check("a5_data", last_acc, 8'hA5);
    check("a5_valid_width", vhi_cnt - v0, 1);
    check("a5_latency_in_window", (lat >= 155 && lat <= 157), 1'b1);
    check("a5_no_overrun", ovr_cnt - o0, 0);
    check("a5_no_frame_err", ferr_cnt - f0, 0);

    // Two frames with consumer stalled
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(10);
    check("stall_valid_held", rx_valid, 1'b1);
    check("stall_old_byte_kept", rx_data, 8'h3C);
    check("stall_overrun_once", ovr_cnt - o0, 1);
    rx_ready = 1'b1;
    idle(1);
    check("stall_valid_cleared", rx_valid, 1'b0);
    idle(5);

    // Short low glitch: false start
    v0 = vhi_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    pin_in = 1'b0;
    idle(4);
    pin_in = 1'b1;
    idle(30);
    check("glitch_went_busy", (busy_cnt - b0) > 0, 1'b1);
    check("glitch_no_valid", vhi_cnt - v0, 0);
    check("glitch_no_frame_err", ferr_cnt - f0, 0);
    check("glitch_busy_back_0", busy, 1'b0);

    // Bad stop bit, then a good frame
    v0 = vhi_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    pin_in = 1'b1;
    idle(20);
    check("ferr_pulse_once", ferr_cnt - f0, 1);
    check("ferr_no_valid", vhi_cnt - v0, 0);
    a0 = acc_cnt;
    send_frame(8'h12, 1'b1);
    idle(20);
    check("after_ferr_accepts", acc_cnt - a0, 1);
    check("after_ferr_data", last_acc, 8'h12);

    // Local driver active, then turnaround glitch inside the guard
    v0 = vhi_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    oe = 1'b1;
    idle(2);
    send_frame(8'h7E, 1'b1);
    idle(2);
    check("oe_never_busy", busy_cnt - b0, 0);
    oe = 1'b0;
    idle(2);
    pin_in = 1'b0;
    idle(2);
    pin_in = 1'b1;
    idle(30);
    check("oe_no_valid", vhi_cnt - v0, 0);
    check("oe_no_frame_err", ferr_cnt - f0, 0);
    rx_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    idle(10);
    check("post_guard_valid", rx_valid, 1'b1);
    check("post_guard_data", rx_data, 8'h81);

    // Reset in the middle of bit 3 of 0xFF while a byte is still pending
    pin_in = 1'b0;
    idle(16);
    pin_in = 1'b1;
    idle(48 + 8);
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    idle(1);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    idle(8 + 64 + 16 + 10);
    a0 = acc_cnt;
    send_frame(8'h0F, 1'b1);
    idle(20);
    check("post_rst_accepts", acc_cnt - a0, 1);
    check("post_rst_data", last_acc, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
